// File: rtl/lcd_reader.sv
// rtl/lcd_reader.sv - HD44780 4-bit read-cycle engine with optional busy-flag polling
module lcd_reader #(
    parameter int SETUP_CYCLES  = 2,
    parameter int ENABLE_CYCLES = 12,
    parameter int GAP_CYCLES    = 50,
    parameter int POLL_LIMIT    = 1000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iStart,
    input  logic       iRegisterSelect,
    input  logic       iPollBusy,
    input  logic [3:0] iLCD_Data,
    output logic       oLCD_Enabled,
    output logic       oLCD_ReadWrite,
    output logic       oLCD_RegisterSelect,
    output logic       oReading,
    output logic [7:0] oData,
    output logic       oBusy,
    output logic       oDone,
    output logic       oTimeout
);

    typedef enum logic [2:0] {
        IDLE, SETUP, EN_HI_H, EN_LO_H, EN_HI_L, EN_LO_L, CHECK, DONE
    } state_t;

    localparam logic [15:0] SETUP_LAST  = 16'(SETUP_CYCLES - 1);
    localparam logic [15:0] ENABLE_LAST = 16'(ENABLE_CYCLES - 1);
    localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
    localparam logic [15:0] POLL_MAX    = 16'(POLL_LIMIT);

    state_t      state;
    state_t      next_state;
    logic [15:0] count;
    logic [15:0] poll_count;
    logic [15:0] poll_next;
    logic        rs_q;
    logic        poll_q;
    logic        timeout_q;
    logic        retry;

    assign poll_next = poll_count + 16'd1;
    // Polling only makes sense on busy-flag reads; BF is the MSB of the assembled byte.
    assign retry = poll_q && !rs_q && oData[7];

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (iStart) next_state = SETUP;
            SETUP:   if (count == SETUP_LAST) next_state = EN_HI_H;
            EN_HI_H: if (count == ENABLE_LAST) next_state = EN_LO_H;
            EN_LO_H: if (count == GAP_LAST) next_state = EN_HI_L;
            EN_HI_L: if (count == ENABLE_LAST) next_state = EN_LO_L;
            EN_LO_L: if (count == GAP_LAST) next_state = CHECK;
            CHECK:   next_state = (retry && poll_next < POLL_MAX) ? SETUP : DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            count      <= 16'd0;
            poll_count <= 16'd0;
            rs_q       <= 1'b0;
            poll_q     <= 1'b0;
            timeout_q  <= 1'b0;
            oData      <= 8'h00;
        end else begin
            state <= next_state;
            if (state == IDLE || next_state != state)
                count <= 16'd0;
            else
                count <= count + 16'd1;

            if (state == IDLE && iStart) begin
                rs_q       <= iRegisterSelect;
                poll_q     <= iPollBusy;
                poll_count <= 16'd0;
                timeout_q  <= 1'b0;
            end

            if (state == EN_HI_H && count == ENABLE_LAST)
                oData[7:4] <= iLCD_Data;
            if (state == EN_HI_L && count == ENABLE_LAST)
                oData[3:0] <= iLCD_Data;

            if (state == CHECK) begin
                poll_count <= poll_next;
                if (retry && poll_next >= POLL_MAX)
                    timeout_q <= 1'b1;
            end
        end
    end

    // Outputs decode straight from state so Reset drops E and RW without waiting for a clock.
    always_comb begin
        oLCD_Enabled        = (state == EN_HI_H) || (state == EN_HI_L);
        oLCD_ReadWrite      = (state != IDLE) && (state != DONE);
        oReading            = oLCD_ReadWrite;
        oLCD_RegisterSelect = (state != IDLE) && rs_q;
        oBusy               = (state != IDLE);
        oDone               = (state == DONE);
        oTimeout            = (state == DONE) && timeout_q;
    end

endmodule

// File: tb/tb_lcd_reader.sv
// tb/tb_lcd_reader.sv - self-checking bench for lcd_reader with an LCD pad model
module tb_lcd_reader;

    localparam int LIM      = 4;
    localparam int GAP      = 50;
    localparam int READ_CYC = 2 + 2 * 12 + 2 * GAP + 1;

    logic       Clock;
    logic       Reset;
    logic       iStart;
    logic       iRegisterSelect;
    logic       iPollBusy;
    logic [3:0] iLCD_Data;
    logic       oLCD_Enabled;
    logic       oLCD_ReadWrite;
    logic       oLCD_RegisterSelect;
    logic       oReading;
    logic [7:0] oData;
    logic       oBusy;
    logic       oDone;
    logic       oTimeout;

    lcd_reader #(.POLL_LIMIT(LIM)) dut (
        .Clock              (Clock),
        .Reset              (Reset),
        .iStart             (iStart),
        .iRegisterSelect    (iRegisterSelect),
        .iPollBusy          (iPollBusy),
        .iLCD_Data          (iLCD_Data),
        .oLCD_Enabled       (oLCD_Enabled),
        .oLCD_ReadWrite     (oLCD_ReadWrite),
        .oLCD_RegisterSelect(oLCD_RegisterSelect),
        .oReading           (oReading),
        .oData              (oData),
        .oBusy              (oBusy),
        .oDone              (oDone),
        .oTimeout           (oTimeout)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic                    rs;
        logic                    poll;
        logic [0:LIM-1][7:0]     b;
        logic [3:0]              reads;
        logic [7:0]              data;
        logic                    to;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: a read sequence ends at the first byte with BF clear, or after LIM reads.
    function automatic vec_t model(input logic rs, input logic poll, input logic [0:LIM-1][7:0] b);
        vec_t v;
        bit   found;
        v.rs = rs; v.poll = poll; v.b = b;
        v.to = 1'b0;
        if (!(poll && !rs)) begin
            v.reads = 4'd1;
        end else begin
            found = 0;
            v.reads = 4'(LIM);
            for (int i = 0; i < LIM; i++)
                if (!found && !b[i][7]) begin
                    found = 1;
                    v.reads = 4'(i + 1);
                end
            v.to = !found;
        end
        v.data = b[int'(v.reads) - 1];
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input string tag);
        int   cyc, rises, done_at, idx;
        logic prev_en, prev_rw, to_seen;
        bit   viol;
        @(negedge Clock);
        iStart = 1'b1; iRegisterSelect = v.rs; iPollBusy = v.poll;
        @(posedge Clock);
        @(negedge Clock);
        iStart = 1'b0; iRegisterSelect = ~v.rs; iPollBusy = ~v.poll;
        cyc = 0; rises = 0; done_at = -1; prev_en = 0; prev_rw = 0; viol = 0; to_seen = 0;
        while (done_at < 0 && cyc < 2000) begin
            if (oLCD_Enabled && !prev_en) begin
                if (oLCD_ReadWrite !== prev_rw) viol = 1;
                idx = rises / 2;
                if (idx < LIM) iLCD_Data = rises[0] ? v.b[idx][3:0] : v.b[idx][7:4];
                rises++;
            end
            if (oLCD_Enabled && !oLCD_ReadWrite) viol = 1;
            if (oReading !== oLCD_ReadWrite) viol = 1;
            if (oLCD_RegisterSelect !== v.rs) viol = 1;
            if (!oBusy) viol = 1;
            if (oTimeout && !oDone) viol = 1;
            iStart = (cyc == 40);
            if (oDone) begin
                done_at = cyc;
                to_seen = oTimeout;
                if (oLCD_ReadWrite || oReading) viol = 1;
            end
            prev_en = oLCD_Enabled; prev_rw = oLCD_ReadWrite;
            if (done_at < 0) begin
                @(negedge Clock);
                cyc++;
            end
        end
        iStart = 1'b0;
        chk({tag, " done_edge"}, 32'(done_at), 32'(READ_CYC * int'(v.reads)));
        chk({tag, " e_pulses"}, 32'(rises), 32'(2 * int'(v.reads)));
        chk({tag, " data"}, 32'(oData), 32'(v.data));
        chk({tag, " timeout"}, 32'(to_seen), 32'(v.to));
        chk({tag, " bus_rules"}, 32'(viol), 32'd0);
        @(negedge Clock);
        chk({tag, " done_one_cycle"}, 32'({oDone, oBusy}), 32'd0);
        @(negedge Clock);
        chk({tag, " no_queued_start"}, 32'(oBusy), 32'd0);
    endtask

    vec_t tbl[6];
    vec_t rv;
    logic [0:LIM-1][7:0] rb;

    initial begin
        int cyc, rises, nd, low_run, min_low, gd;
        int dones[3];
        logic prev_en, prev_done;
        bit viol, seen;

        Reset = 1'b1; iStart = 1'b0; iRegisterSelect = 1'b0; iPollBusy = 1'b0; iLCD_Data = 4'h0;
        tbl[0] = '{1'b1, 1'b0, {8'hA5, 8'h00, 8'h00, 8'h00}, 4'd1, 8'hA5, 1'b0};
        tbl[1] = '{1'b0, 1'b1, {8'h8A, 8'hC3, 8'hFF, 8'h07}, 4'd4, 8'h07, 1'b0};
        tbl[2] = '{1'b0, 1'b1, {8'h80, 8'h80, 8'h80, 8'h80}, 4'd4, 8'h80, 1'b1};
        tbl[3] = '{1'b1, 1'b1, {8'hFF, 8'h11, 8'h22, 8'h33}, 4'd1, 8'hFF, 1'b0};
        tbl[4] = '{1'b0, 1'b0, {8'h9C, 8'h00, 8'h00, 8'h00}, 4'd1, 8'h9C, 1'b0};
        tbl[5] = '{1'b0, 1'b1, {8'h3B, 8'h80, 8'h80, 8'h80}, 4'd1, 8'h3B, 1'b0};

        repeat (3) @(posedge Clock);
        #1;
        chk("reset_outputs",
            32'({oLCD_Enabled, oLCD_ReadWrite, oLCD_RegisterSelect, oReading, oBusy, oDone, oTimeout}),
            32'd0);
        chk("reset_data", 32'(oData), 32'h00);
        @(negedge Clock);
        Reset = 1'b0;

        for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 24; i++) begin
            for (int k = 0; k < LIM; k++) begin
                rb[k] = 8'($urandom);
                rb[k][7] = ($urandom_range(0, 9) < 7);
            end
            rv = model(1'($urandom), 1'($urandom), rb);
            run_txn(rv, $sformatf("rnd%0d", i));
        end

        // Reset during EN_HI_L of the second poll iteration.
        @(negedge Clock);
        iStart = 1'b1; iRegisterSelect = 1'b0; iPollBusy = 1'b1; iLCD_Data = 4'h8;
        @(negedge Clock);
        iStart = 1'b0;
        rises = 0; prev_en = 0; cyc = 0;
        while (rises < 4 && cyc < 1000) begin
            if (oLCD_Enabled && !prev_en) rises++;
            prev_en = oLCD_Enabled;
            @(negedge Clock);
            cyc++;
        end
        chk("rst_reached_2nd_low_nibble", 32'(rises), 32'd4);
        @(negedge Clock);
        chk("rst_pre_e_high", 32'(oLCD_Enabled), 32'd1);
        Reset = 1'b1;
        #1;
        chk("rst_async_outputs",
            32'({oLCD_Enabled, oLCD_ReadWrite, oReading, oBusy, oLCD_RegisterSelect}), 32'd0);
        chk("rst_data_cleared", 32'(oData), 32'h00);
        repeat (2) @(negedge Clock);
        Reset = 1'b0;
        seen = 0;
        repeat (200) begin
            @(negedge Clock);
            if (oDone || oBusy) seen = 1;
        end
        chk("rst_no_done", 32'(seen), 32'd0);

        // iStart held high: back-to-back reads.
        @(negedge Clock);
        iStart = 1'b1; iRegisterSelect = 1'b1; iPollBusy = 1'b0; iLCD_Data = 4'h3;
        @(posedge Clock);
        @(negedge Clock);
        cyc = 0; nd = 0; low_run = 0; min_low = 1 << 30; prev_en = 0; prev_done = 0; viol = 0;
        while (nd < 3 && cyc < 1000) begin
            if (oLCD_Enabled && !prev_en && low_run > 0 && low_run < min_low) min_low = low_run;
            low_run = oLCD_Enabled ? 0 : (prev_en ? 1 : (low_run > 0 ? low_run + 1 : 0));
            if (oDone && prev_done) viol = 1;
            if (oDone) begin
                dones[nd] = cyc;
                nd++;
            end
            prev_en = oLCD_Enabled; prev_done = oDone;
            @(negedge Clock);
            cyc++;
        end
        iStart = 1'b0;
        chk("b2b_done_count", 32'(nd), 32'd3);
        chk("b2b_first_done", 32'(dones[0]), 32'(READ_CYC));
        chk("b2b_spacing1", 32'(dones[1] - dones[0]), 32'(READ_CYC + 2));
        chk("b2b_spacing2", 32'(dones[2] - dones[1]), 32'(READ_CYC + 2));
        chk("b2b_done_single", 32'(viol), 32'd0);
        chk("b2b_e_low_min_ok", 32'(min_low >= GAP), 32'd1);
        chk("b2b_data", 32'(oData), 32'h33);
        gd = 0;
        while (oBusy && gd < 500) begin
            @(negedge Clock);
            gd++;
        end
        chk("b2b_returns_idle", 32'(oBusy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_reader.md
# lcd_reader

Read-side companion to the 4-bit LCD nibble writer. It runs HD44780-style read cycles (RW=1) over the shared 4-bit LCD data bus and returns a full byte: either the busy flag plus address counter (RS=0) or a DDRAM/CGRAM data byte (RS=1). An optional poll mode repeats busy-flag reads until BF clears, so the writer sequencer can wait on the controller instead of using fixed delays. It sits beside the writer, and its bus-ownership flag drives the pad tristate mux.

## Interface
Parameters:
- SETUP_CYCLES, 2: cycles with RS/RW stable before E rises (tAS ≥ 40 ns at 50 MHz).
- ENABLE_CYCLES, 12: E high time per nibble; data is sampled on the last cycle (≥ 230 ns).
- GAP_CYCLES, 50: E low time after each nibble (≥ 1 µs).
- POLL_LIMIT, 1000: maximum reads in poll mode before timeout; must be ≥ 1.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high; all state and outputs cleared immediately.
- iStart  in  1  request a read; sampled only in IDLE.
- iRegisterSelect  in  1  0 = busy flag/address, 1 = data RAM; latched when iStart is accepted.
- iPollBusy  in  1  latched with iStart; honoured only when the latched RS=0.
- iLCD_Data  in  4  LCD DB7..DB4 from the pads.
- oLCD_Enabled  out  1  LCD E.
- oLCD_ReadWrite  out  1  LCD RW.
- oLCD_RegisterSelect  out  1  LCD RS.
- oReading  out  1  reader owns the bus; FPGA data drivers must be tristated.
- oData  out  8  last byte read, formed as {high nibble, low nibble}.
- oBusy  out  1  high whenever the block is not in IDLE.
- oDone  out  1  one-cycle completion pulse.
- oTimeout  out  1  one-cycle pulse coincident with oDone when poll mode gives up.

## Operation
- States: IDLE, SETUP, EN_HI_H, EN_LO_H, EN_HI_L, EN_LO_L, CHECK, DONE.
- One 16-bit cycle counter, cleared on every state entry. A state exits when count = its parameter − 1.
- IDLE: outputs are at their idle values. If iStart=1, latch RS and poll, clear the poll counter, go to SETUP. iStart=0 stays in IDLE.
- SETUP: RW=1, RS=latched value, E=0, oReading=1. Lasts SETUP_CYCLES.
- EN_HI_H: E=1. On its last cycle, capture iLCD_Data into oData[7:4]. Lasts ENABLE_CYCLES.
- EN_LO_H: E=0. Lasts GAP_CYCLES.
- EN_HI_L: E=1. On its last cycle, capture iLCD_Data into oData[3:0].
- EN_LO_L: E=0 with RW still 1 (address hold). Lasts GAP_CYCLES.
- CHECK, one cycle; the poll counter increments here:
  - Poll mode, oData[7]=1, and the count after increment < POLL_LIMIT: go to SETUP.
  - Poll mode, oData[7]=1, and the count after increment reaches POLL_LIMIT: set the timeout flag, go to DONE.
  - Otherwise: go to DONE.
- DONE, one cycle: oDone=1, oTimeout = timeout flag, RW=0, oReading=0. Next state is IDLE.
- oReading and oLCD_ReadWrite are high exactly from SETUP through CHECK.
- oLCD_RegisterSelect holds the latched RS from SETUP through DONE, and is 0 in IDLE.
- oData holds its value until the next capture.
- iStart during any non-IDLE state is ignored and is not queued.

## Timing
- Reset values: oLCD_Enabled=0, oLCD_ReadWrite=0, oLCD_RegisterSelect=0, oReading=0, oData=8'h00, oBusy=0, oDone=0, oTimeout=0, state=IDLE.
- Single read latency: oDone is high in the cycle after edge SETUP_CYCLES + 2·ENABLE_CYCLES + 2·GAP_CYCLES + 1, counted from the edge that accepts iStart. With defaults this is edge 127.
- Each extra poll iteration adds SETUP_CYCLES + 2·ENABLE_CYCLES + 2·GAP_CYCLES + 1 = 127 cycles.
- E never rises in the same cycle RW changes; SETUP always separates them.
- Reset asserted mid-operation: E and RW drop asynchronously, no oDone is produced, and the block returns to IDLE.
- iStart=1 in the same cycle that Reset deasserts is ignored; the first acceptable edge is the one after Reset is low.
- oDone cannot recur sooner than 2 cycles after the previous pulse (DONE → IDLE → accept).

## Test plan
- RS=1 read, iLCD_Data=4'hA during the first E and 4'h5 during the second -> oData=8'hA5, oDone at edge 127, oTimeout=0, RS=1 throughout, RW=1 only during SETUP..CHECK.
- Poll mode with BF=1 for 3 reads, then the pad shows 4'h0 and 4'h7 -> exactly 4 E-high pairs, oData=8'h07, oDone at edge 4·127 − 1 + 1 after the start, oTimeout=0.
- Poll mode with POLL_LIMIT=4 and BF stuck at 1 (pad = 4'h8) -> 4 reads, then oDone and oTimeout pulse together, oData=8'h80.
- iPollBusy=1 with RS=1 and pad = 4'hF -> single read, oData=8'hFF, no repeat.
- Reset asserted during EN_HI_L of the 2nd poll iteration -> E=0 and RW=0 in the same cycle, no oDone, oBusy=0.
- iStart held high continuously -> back-to-back reads, with E-low ≥ GAP_CYCLES between transactions and a one-cycle oDone on each.
